// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller.
// FSM state enum, forwarding select codes and a register-match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // x0 is hardwired zero, so it never takes part in a dependency.
    function automatic logic reg_match(
        input logic [4:0] rd,
        input logic [4:0] rs
    );
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one ALU source in Execute.
// Ports: rs_e_i, rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i -> fwd_o.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    // Memory stage holds the younger result, so it wins over Writeback.
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && reg_match(rd_m_i, rs_e_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && reg_match(rd_w_i, rs_e_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// data-memory wait stall with timeout FSM and sticky mem_timeout flag.
// Ports: clk, rst (async active-low), register ids D/E/M/W, RegWriteM/W,
// LoadE, PCSrcE, MemReqM/MemReadyM -> Stall*, Flush*, Forward*E,
// mem_timeout. Define HAZARD_PERF_CNT_EN to add stall_cnt/flush_cnt.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    hz_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          lw_stall;
    logic          mem_wait;
    logic          br_flush;

    forward_unit u_fwd_a (
        .rs_e_i        (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardAE)
    );

    forward_unit u_fwd_b (
        .rs_e_i        (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardBE)
    );

    assign lw_stall = LoadE && (RdE != 5'd0)
                    && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_wait = MemReqM && !MemReadyM;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_wait) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (state_d == ST_RUN) cnt_d = '0;
    end

    // Stall/flush priority: memory wait or error, then branch, then load-use.
    // Branch/load-use also act in MEM_WAIT once the access completes, so a
    // branch held in Execute during the wait is not lost on release.
    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushW   = 1'b0;
        br_flush = 1'b0;
        if (!rst) begin
            br_flush = 1'b0;
        end else if (mem_wait || state_q == ST_ERROR) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            br_flush = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (br_flush && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table for the
// combinational paths plus sequences for bubble, memory wait and timeout.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, LoadE, PCSrcE;
    logic       MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .LoadE       (LoadE),
        .PCSrcE      (PCSrcE),
        .MemReqM     (MemReqM),
        .MemReadyM   (MemReadyM),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .mem_timeout (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, lde, pcs, req, rdy;
        logic [3:0] ex_stall;
        logic [2:0] ex_flush;
        logic [1:0] ex_fa, ex_fb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string n,
        input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
        input logic rwm, rww, lde, pcs, req, rdy,
        input logic [3:0] st, input logic [2:0] fl,
        input logic [1:0] fa, fb
    );
        vec_t v;
        v.name = n;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw;
        v.rwm = rwm; v.rww = rww; v.lde = lde; v.pcs = pcs;
        v.req = req; v.rdy = rdy;
        v.ex_stall = st; v.ex_flush = fl; v.ex_fa = fa; v.ex_fb = fb;
        return v;
    endfunction

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [3:0] stalls();
        return {StallF, StallD, StallE, StallM};
    endfunction

    function automatic logic [2:0] flushes();
        return {FlushD, FlushE, FlushW};
    endfunction

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic apply(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
        RegWriteM = v.rwm; RegWriteW = v.rww;
        LoadE = v.lde; PCSrcE = v.pcs;
        MemReqM = v.req; MemReadyM = v.rdy;
    endtask

    initial begin
        //           name    rs1d rs2d rs1e rs2e rdE rdM rdW rwm rww ld pc rq ry
        vecs.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("fwd_mem", 0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0,
                          4'b0000, 3'b000, 2'b10, 2'b00));
        vecs.push_back(mk("fwd_rdm0", 0, 0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0,
                          4'b0000, 3'b000, 2'b01, 2'b00));
        vecs.push_back(mk("fwd_wb_ab", 0, 0, 5, 5, 0, 5, 5, 0, 1, 0, 0, 0, 0,
                          4'b0000, 3'b000, 2'b01, 2'b01));
        vecs.push_back(mk("fwd_x0", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,
                          4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("fwd_b_mem", 0, 0, 3, 9, 0, 9, 3, 1, 1, 0, 0, 0, 0,
                          4'b0000, 3'b000, 2'b01, 2'b10));
        vecs.push_back(mk("fwd_nowe", 0, 0, 4, 6, 0, 4, 6, 0, 0, 0, 0, 0, 0,
                          4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("lw_rs2", 0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0,
                          4'b1100, 3'b010, 2'b00, 2'b00));
        vecs.push_back(mk("lw_rs1", 8, 0, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 0,
                          4'b1100, 3'b010, 2'b00, 2'b00));
        vecs.push_back(mk("lw_rd0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,
                          4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("nolw", 7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0,
                          4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("br_lw", 0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0,
                          4'b0000, 3'b110, 2'b00, 2'b00));
        vecs.push_back(mk("mem_fast", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                          4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("mem_br", 0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 1, 0,
                          4'b1111, 3'b001, 2'b00, 2'b00));

        // Reset state: outputs forced low even with a memory wait pending.
        idle();
        rst = 1'b0;
        MemReqM = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 32'(stalls()), 32'h0);
        check("rst_flush", 32'(flushes()), 32'h0);
        check("rst_tmo", 32'(mem_timeout), 32'h0);
        idle();
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check({vecs[i].name, "_stall"}, 32'(stalls()),
                  32'(vecs[i].ex_stall));
            check({vecs[i].name, "_flush"}, 32'(flushes()),
                  32'(vecs[i].ex_flush));
            check({vecs[i].name, "_fa"}, 32'(ForwardAE), 32'(vecs[i].ex_fa));
            check({vecs[i].name, "_fb"}, 32'(ForwardBE), 32'(vecs[i].ex_fb));
        end

        // Last vector left a memory wait; let it complete.
        @(negedge clk);
        idle();
        MemReadyM = 1'b1;
        @(negedge clk);
        idle();
        #1;
        check("post_tbl", 32'({stalls(), flushes()}), 32'h0);

        // Load-use bubble lasts one cycle, then the load leaves Execute.
        @(negedge clk);
        LoadE = 1; RdE = 7; Rs2D = 7;
        #1;
        check("bub_c1", 32'({stalls(), flushes()}), 32'b1100_010);
        @(negedge clk);
        LoadE = 0; RdE = 0;
        #1;
        check("bub_c2", 32'({stalls(), flushes()}), 32'h0);

        // Memory wait of three cycles, then ready.
        @(negedge clk);
        idle();
        MemReqM = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("mw_c%0d", c), 32'({stalls(), flushes()}),
                  32'b1111_001);
            @(negedge clk);
        end
        MemReadyM = 1;
        #1;
        check("mw_rdy", 32'({stalls(), flushes()}), 32'h0);
        @(negedge clk);
        idle();
        PCSrcE = 1;
        #1;
        check("mw_br", 32'({stalls(), flushes()}), 32'b0000_110);
        check("mw_tmo", 32'(mem_timeout), 32'h0);

        // Timeout: one RUN wait cycle plus 16 MEM_WAIT cycles.
        @(negedge clk);
        idle();
        MemReqM = 1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            #1;
            if (k >= 15)
                check($sformatf("to_k%0d", k), 32'(mem_timeout),
                      32'(k == 17));
        end
        MemReqM = 0;
        #1;
        check("err_stall", 32'({stalls(), flushes()}), 32'b1111_001);
        @(negedge clk);
        MemReadyM = 1;
        #1;
        check("err_sticky", 32'(mem_timeout), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("err_rst_tmo", 32'(mem_timeout), 32'h0);
        check("err_rst_st", 32'({stalls(), flushes()}), 32'h0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        PCSrcE = 1;
        #1;
        check("rst_resume", 32'({stalls(), flushes()}), 32'b0000_110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
